// File: rtl/data_mem_responder_if.sv
// CPU data-memory request/response bundle: request fields, CPU stall input, read data, stall request and response valid.
interface data_mem_responder_if;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_stall;
  logic [31:0] mem_rdata;
  logic        stallreq_from_mem;
  logic        resp_valid;

  modport master (
    output mem_en, mem_we, sel, mem_addr, mem_wdata, cpu_stall,
    input  mem_rdata, stallreq_from_mem, resp_valid
  );

  modport slave (
    input  mem_en, mem_we, sel, mem_addr, mem_wdata, cpu_stall,
    output mem_rdata, stallreq_from_mem, resp_valid
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with fixed wait states; stall is held for WAIT_CYCLES+1 cycles and the result is presented in DONE.
// DONE holds while the CPU is stalled elsewhere, and exits at once on a flushed request (mem_en low).
module data_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              accept;
  logic              access;
  logic [31:0]       mem [DEPTH];

  // Sub-word offset and bits above the storage depth never select a word.
  logic unused_addr;
  assign unused_addr = ^{bus.mem_addr[31:ADDR_W+2], bus.mem_addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_en) begin
          accept  = 1'b1;
          state_d = BUSY;
          cnt_d   = 4'(WAIT_CYCLES - 1);
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!bus.cpu_stall || !bus.mem_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (access && !we_q) rdata_q <= mem[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= bus.mem_addr[ADDR_W+1:2];
      we_q    <= bus.mem_we;
      sel_q   <= bus.sel;
      wdata_q <= bus.mem_wdata;
    end
  end

  // Storage has no reset; a reset landing on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && access && we_q) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign bus.stallreq_from_mem = !rst && ((state_q == IDLE && bus.mem_en) || state_q == BUSY);
  assign bus.resp_valid        = (state_q == DONE);
  assign bus.mem_rdata         = rdata_q;
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning log2 of the storage depth in 32-bit words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the number of BUSY cycles per access; legal range 1..15.
REQ-003 SHALL be one clock; reset is synchronous and active-high. The ports are clk and rst.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port mem_en  input  1  CPU data request valid.
REQ-007 SHALL have port mem_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port sel  input  4  byte-lane write enables; bit i covers wdata[8i+7:8i].
REQ-009 SHALL have port mem_addr  input  32  byte address.
REQ-010 SHALL have port mem_wdata  input  32  write data, already lane-aligned by the CPU.
REQ-011 SHALL have port cpu_stall  input  1  CPU MEM stage held this cycle by any source.
REQ-012 SHALL have port mem_rdata  output  32  read data, a full word.
REQ-013 SHALL have port stallreq_from_mem  output  1  stall request to the CPU hazard unit.
REQ-014 SHALL have port resp_valid  output  1  high while in state DONE.

Function
REQ-015 SHALL implement an FSM with states IDLE, BUSY and DONE, plus a 4-bit down-counter cnt.
REQ-016 SHALL go from IDLE to BUSY at the edge where mem_en=1, loading cnt=WAIT_CYCLES-1 and latching addr, we, sel and wdata.
REQ-017 SHALL assert stallreq_from_mem combinationally in IDLE whenever mem_en=1, and throughout BUSY.
REQ-018 SHALL hold in BUSY and decrement cnt each edge while cnt!=0.
REQ-019 SHALL perform the access at the BUSY edge where cnt==0, then enter DONE.
- Write: update only the bytes selected by sel.
- Read: register the word into rdata_q.
REQ-020 SHALL index the word as latched addr[ADDR_W+1:2]; upper address bits are ignored, so addresses wrap modulo depth.
REQ-021 SHALL ignore addr[1:0]; mem_rdata is always the full aligned word.
REQ-022 SHALL deassert stallreq_from_mem in DONE and drive mem_rdata=rdata_q.
REQ-023 SHALL go from DONE to IDLE at the first edge with cpu_stall=0.
REQ-024 SHALL stay in DONE while cpu_stall=1, with no second access and rdata_q held stable.
REQ-025 SHALL go from DONE to IDLE when mem_en=0 even if cpu_stall=1 (flushed request).
REQ-026 SHALL not start the next request in the DONE cycle; a back-to-back request is accepted from IDLE on the following cycle.
REQ-027 SHALL ignore mem_en, mem_addr and mem_wdata changes during BUSY; the latched values are used.
REQ-028 SHALL give a total stall of WAIT_CYCLES+1 cycles per access, with data valid in the cycle after the stall drops.
REQ-029 SHALL consume full latency for a write with sel=4'b0000 and leave storage unchanged.
REQ-030 SHALL update mem_rdata only on reads; after a write, mem_rdata keeps its previous value.
REQ-031 SHALL give a read of a just-written address the new data.

Reset
REQ-032 SHALL put the FSM in IDLE and set cnt=0, rdata_q=0, mem_rdata=0 and resp_valid=0 on rst=1 at a clock edge.
REQ-033 SHALL drive stallreq_from_mem=0 while rst=1, regardless of mem_en.
REQ-034 SHALL not initialise storage contents on reset.
REQ-035 SHALL abort an access that rst hits in BUSY before the cnt==0 edge, with no write performed.

Verification
REQ-036 SHALL cover: WAIT_CYCLES=2, write addr 0x10 wdata 0xDEADBEEF sel 1111 -> stall high 3 cycles, resp_valid in cycle 3, word 4 = 0xDEADBEEF.
REQ-037 SHALL cover: read addr 0x10 after REQ-036 -> mem_rdata=0xDEADBEEF in the first cycle stall is low.
REQ-038 SHALL cover: word 4 = 0xDEADBEEF, write 0x00001234 with sel 0011 then read -> 0xDEAD1234; then write sel 0000 and read -> unchanged.
REQ-039 SHALL cover: read completes with cpu_stall=1 held 4 cycles -> stays DONE, exactly one access, mem_rdata stable, IDLE the edge after cpu_stall=0.
REQ-040 SHALL cover: ADDR_W=10, write addr 0x1010 = 0x55 -> read addr 0x0010 returns 0x55 (wrap).
REQ-041 SHALL cover: rst pulsed in the 2nd BUSY cycle of a write to 0x20 holding 0x11111111 -> FSM IDLE, stall 0, mem_rdata 0, word 8 still 0x11111111.
